// File: rtl/freq_meter_ctrl.sv
// freq_meter_ctrl: measurement sequencer for the frequency meter.
// Times 2^k periods of sig_in in clk cycles and returns the average.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   sig_in       raw measured signal, asynchronous to clk
//   start        one-cycle request to begin a measurement (IDLE only)
//   avg_log2     averaging exponent k, clamped to MAX_LOG2, latched on start
//   busy         high while arming or measuring
//   result_valid high while a result is offered
//   result_ready consumer accepts the result
//   period       averaged period in clk cycles (0 on timeout)
//   timeout      result is a timeout
//   edge_cnt     rising edges seen in the current/last run, saturating
`timescale 1ns/1ps
module freq_meter_ctrl #(
    parameter int CNT_W       = 24,
    parameter int MAX_LOG2    = 7,
    parameter int TIMEOUT_CYC = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             start,
    input  logic [2:0]       avg_log2,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] period,
    output logic             timeout,
    output logic [7:0]       edge_cnt
);

    localparam int SUM_W = CNT_W + MAX_LOG2;
    localparam int REM_W = MAX_LOG2 + 1;
    localparam logic [2:0]       K_MAX     = 3'(MAX_LOG2);
    localparam logic [CNT_W-1:0] GAP_LIMIT = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic             s_meta;
    logic             s_sync;
    logic             s_dly;
    logic             rise;

    logic [CNT_W-1:0] gap;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] sum_new;
    logic [REM_W-1:0] rem;
    logic [2:0]       k;
    logic [2:0]       k_in;
    logic [CNT_W-1:0] avg_calc;
    logic             gap_hit;

    logic             do_start;
    logic             do_first;
    logic             do_acc;
    logic             do_fin;
    logic             do_to;

    // Two-flop synchroniser plus a delay flop for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_meta <= 1'b0;
            s_sync <= 1'b0;
            s_dly  <= 1'b0;
        end else begin
            s_meta <= sig_in;
            s_sync <= s_meta;
            s_dly  <= s_sync;
        end
    end

    assign rise = s_sync & ~s_dly;

    assign k_in = (int'(avg_log2) > MAX_LOG2) ? K_MAX : avg_log2;

    assign sum_new  = sum + SUM_W'(gap);
    assign avg_calc = CNT_W'(sum_new >> k);

    // A rise in the same cycle takes priority over gap_hit in the FSM,
    // so a period of exactly TIMEOUT_CYC is still measured.
    assign gap_hit = (gap >= GAP_LIMIT);

    assign busy         = (state == ARM) || (state == MEASURE);
    assign result_valid = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_start   = 1'b0;
        do_first   = 1'b0;
        do_acc     = 1'b0;
        do_fin     = 1'b0;
        do_to      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    do_start   = 1'b1;
                    state_next = ARM;
                end
            end
            ARM: begin
                if (rise) begin
                    do_first   = 1'b1;
                    state_next = MEASURE;
                end else if (gap_hit) begin
                    do_to      = 1'b1;
                    state_next = DONE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    do_acc = 1'b1;
                    if (rem == REM_W'(1)) begin
                        do_fin     = 1'b1;
                        state_next = DONE;
                    end
                end else if (gap_hit) begin
                    do_to      = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Gap counter: cycles since the last rise, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap <= '0;
        end else if (do_start) begin
            gap <= '0;
        end else if (rise) begin
            gap <= CNT_W'(1);
        end else if (gap != '1) begin
            gap <= gap + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum <= '0;
            rem <= '0;
            k   <= '0;
        end else if (do_start) begin
            sum <= '0;
            rem <= REM_W'(1) << k_in;
            k   <= k_in;
        end else if (do_acc) begin
            sum <= sum_new;
            rem <= rem - REM_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_cnt <= '0;
        end else if (do_start) begin
            edge_cnt <= '0;
        end else if (do_first) begin
            edge_cnt <= 8'd1;
        end else if (do_acc && (edge_cnt != 8'hFF)) begin
            edge_cnt <= edge_cnt + 8'd1;
        end
    end

    // Result registers hold from DONE until the next start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period  <= '0;
            timeout <= 1'b0;
        end else if (do_start) begin
            period  <= '0;
            timeout <= 1'b0;
        end else if (do_fin) begin
            period  <= avg_calc;
            timeout <= 1'b0;
        end else if (do_to) begin
            period  <= '0;
            timeout <= 1'b1;
        end
    end

endmodule
